// File: rtl/cordic_stream.sv
// cordic_stream: fully pipelined CORDIC with per-sample rotation/vectoring mode and valid/ready flow control.
// Define CORDIC_GAIN_COMP_EN to add a registered 1/K gain-compensation output stage (one extra cycle of latency).
module cordic_stream #(
    parameter int BIT_WIDTH  = 8,
    parameter int ITERATIONS = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mode,
    input  logic signed [BIT_WIDTH-1:0] Xin,
    input  logic signed [BIT_WIDTH-1:0] Yin,
    input  logic        [31:0]          angle,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH+1:0] Xout,
    output logic signed [BIT_WIDTH+1:0] Yout,
    output logic        [31:0]          Zout
);

    localparam int          W       = BIT_WIDTH + 2;
    localparam logic [31:0] QUARTER = 32'h4000_0000;

    typedef logic signed [W-1:0] xy_t;

    // round(atan(2^-i) * 2^32 / (2*pi))
    function automatic logic [31:0] atan_lut(input int i);
        case (i)
            0:  return 32'h2000_0000;  1:  return 32'h12E4_051E;
            2:  return 32'h09FB_385B;  3:  return 32'h0511_11D4;
            4:  return 32'h028B_0D43;  5:  return 32'h0145_D7E1;
            6:  return 32'h00A2_F61E;  7:  return 32'h0051_7C55;
            8:  return 32'h0028_BE53;  9:  return 32'h0014_5F2F;
            10: return 32'h000A_2F98;  11: return 32'h0005_17CC;
            12: return 32'h0002_8BE6;  13: return 32'h0001_45F3;
            14: return 32'h0000_A2FA;  15: return 32'h0000_517D;
            16: return 32'h0000_28BE;  17: return 32'h0000_145F;
            18: return 32'h0000_0A30;  19: return 32'h0000_0518;
            20: return 32'h0000_028C;  21: return 32'h0000_0146;
            22: return 32'h0000_00A3;  23: return 32'h0000_0051;
            24: return 32'h0000_0029;  25: return 32'h0000_0014;
            26: return 32'h0000_000A;  27: return 32'h0000_0005;
            28: return 32'h0000_0003;  29: return 32'h0000_0001;
            default: return 32'h0;
        endcase
    endfunction

    // Index 0 is the pre-rotation register; index i+1 is the output of micro-rotation stage i.
    xy_t         x_q [ITERATIONS+1];
    xy_t         y_q [ITERATIONS+1];
    logic [31:0] z_q [ITERATIONS+1];
    logic        v_q [ITERATIONS+1];
    logic        m_q [ITERATIONS];

    xy_t         x_nxt [ITERATIONS];
    xy_t         y_nxt [ITERATIONS];
    logic [31:0] z_nxt [ITERATIONS];

    xy_t         xs, ys, pre_x, pre_y;
    logic [31:0] pre_z;
    logic        stall;

    assign xs = xy_t'(Xin);
    assign ys = xy_t'(Yin);

    // Quadrant pre-rotation by +/-90 degrees brings every input into the CORDIC convergence range.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pre_x = xs;
        pre_y = ys;
        pre_z = angle;
        if (!in_mode) begin
            if (angle[31:30] == 2'b01) begin
                pre_x = -ys;
                pre_y = xs;
                pre_z = angle - QUARTER;
            end else if (angle[31:30] == 2'b10) begin
                pre_x = ys;
                pre_y = -xs;
                pre_z = angle + QUARTER;
            end
        end else begin
            pre_z = '0;
            if (xs < 0) begin
                if (ys >= 0) begin
                    pre_x = ys;
                    pre_y = -xs;
                    pre_z = QUARTER;
                end else begin
                    pre_x = -ys;
                    pre_y = xs;
                    pre_z = -QUARTER;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ITERATIONS; i++) begin
            if (m_q[i] ? y_q[i][W-1] : !z_q[i][31]) begin
                x_nxt[i] = x_q[i] - (y_q[i] >>> i);
                y_nxt[i] = y_q[i] + (x_q[i] >>> i);
                z_nxt[i] = z_q[i] - atan_lut(i);
            end else begin
                x_nxt[i] = x_q[i] + (y_q[i] >>> i);
                y_nxt[i] = y_q[i] - (x_q[i] >>> i);
                z_nxt[i] = z_q[i] + atan_lut(i);
            end
        end
    end

    // NOTE: datapath registers are reset along with the valid bits so outputs read zero straight out of reset;
    // all sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ITERATIONS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
            for (int i = 0; i < ITERATIONS; i++) m_q[i] <= 1'b0;
        end else if (!stall) begin
            v_q[0] <= in_valid;
            m_q[0] <= in_mode;
            x_q[0] <= pre_x;
            y_q[0] <= pre_y;
            z_q[0] <= pre_z;
            for (int i = 0; i < ITERATIONS; i++) begin
                v_q[i+1] <= v_q[i];
                x_q[i+1] <= x_nxt[i];
                y_q[i+1] <= y_nxt[i];
                z_q[i+1] <= z_nxt[i];
            end
            for (int i = 1; i < ITERATIONS; i++) m_q[i] <= m_q[i-1];
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int                PW        = W + 18;
    localparam logic signed [17:0] GAIN_COMP = 18'sd39797;

    logic signed [PW-1:0] x_prod, y_prod;
    xy_t                  x_g, y_g;
    logic [31:0]          z_g;
    logic                 v_g;

    assign x_prod = PW'(x_q[ITERATIONS]) * PW'(GAIN_COMP);
    assign y_prod = PW'(y_q[ITERATIONS]) * PW'(GAIN_COMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_g <= 1'b0;
            x_g <= '0;
            y_g <= '0;
            z_g <= '0;
        end else if (!stall) begin
            v_g <= v_q[ITERATIONS];
            x_g <= xy_t'(x_prod >>> 16);
            y_g <= xy_t'(y_prod >>> 16);
            z_g <= z_q[ITERATIONS];
        end
    end

    assign out_valid = v_g;
    assign Xout      = x_g;
    assign Yout      = y_g;
    assign Zout      = z_g;
`else
    assign out_valid = v_q[ITERATIONS];
    assign Xout      = x_q[ITERATIONS];
    assign Yout      = y_q[ITERATIONS];
    assign Zout      = z_q[ITERATIONS];
`endif

    // The whole pipeline freezes while the consumer refuses a presented result.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

endmodule

// File: tb/tb_cordic_stream.sv
// Self-checking bench for cordic_stream: directed quadrant/latency/reset cases plus randomized streams
// scored against a floating-point-derived CORDIC reference model.
module tb_cordic_stream;

    localparam int BW = 8;
    localparam int IT = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT    = IT + 2;
    localparam int A_ROT  = 45;
    localparam int A_RTOL = 1;
    localparam int A_VEC  = 90;
`else
    localparam int LAT    = IT + 1;
    localparam int A_ROT  = 74;
    localparam int A_RTOL = 2;
    localparam int A_VEC  = 149;
`endif

    typedef struct {
        longint      x;
        longint      y;
        logic [31:0] z;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   in_mode = 1'b0;
    logic signed [BW-1:0]   Xin = '0;
    logic signed [BW-1:0]   Yin = '0;
    logic        [31:0]     angle = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic signed [BW+1:0]   Xout;
    logic signed [BW+1:0]   Yout;
    logic        [31:0]     Zout;

    cordic_stream #(.BIT_WIDTH(BW), .ITERATIONS(IT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .Xin(Xin), .Yin(Yin), .angle(angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .Xout(Xout), .Yout(Yout), .Zout(Zout)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] atan_tab [30];
    res_t        exp_q [$];
    int          n_out = 0;
    int          lo_cnt = 0;
    bit          drv_done = 1'b0;
    bit          hold_prev = 1'b0;
    longint      hx, hy;
    logic [31:0] hz;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint angerr(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        return absl(longint'($signed(d)));
    endfunction

    // Reference: quadrant fold, then ITERATIONS micro-rotations on wide integers, optional 1/K scaling.
    function automatic res_t model(input logic mode, input longint xi, input longint yi, input logic [31:0] ang);
        res_t   r;
        longint x, y, xn, yn;
        logic [31:0] z;
        bit     d;
        x = xi; y = yi; z = ang;
        if (!mode) begin
            if (ang[31:30] == 2'b01)      begin x = -yi; y = xi;  z = ang - 32'h4000_0000; end
            else if (ang[31:30] == 2'b10) begin x = yi;  y = -xi; z = ang + 32'h4000_0000; end
        end else begin
            z = 32'h0;
            if (xi < 0 && yi >= 0)     begin x = yi;  y = -xi; z = 32'h4000_0000; end
            else if (xi < 0 && yi < 0) begin x = -yi; y = xi;  z = 32'hC000_0000; end
        end
        for (int i = 0; i < IT; i++) begin
            d  = mode ? (y < 0) : (z[31] == 1'b0);
            xn = d ? x - (y >>> i) : x + (y >>> i);
            yn = d ? y + (x >>> i) : y - (x >>> i);
            z  = d ? z - atan_tab[i] : z + atan_tab[i];
            x  = xn;
            y  = yn;
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x * 39797) >>> 16;
        y = (y * 39797) >>> 16;
`endif
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    // Scoreboard, handshake rule and output-hold checks, all sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            res_t e;
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (!in_ready) lo_cnt++;
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_x", longint'(Xout), hx);
                check("hold_y", longint'(Yout), hy);
                check("hold_z", Zout, hz);
            end
            hold_prev = out_valid && !out_ready;
            hx = Xout; hy = Yout; hz = Zout;
            if (in_valid && in_ready)
                exp_q.push_back(model(in_mode, longint'(Xin), longint'(Yin), angle));
            if (out_valid && out_ready) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("res_x", longint'(Xout), e.x);
                    check("res_y", longint'(Yout), e.y);
                    check("res_z", Zout, e.z);
                end
                n_out++;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send(input logic m, input int x, input int y, input logic [31:0] a);
        int n;
        n = 0;
        in_mode = m;
        Xin = x[BW-1:0];
        Yin = y[BW-1:0];
        angle = a;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // One sample into an idle pipe; lat counts edges from the accepting edge to the one raising out_valid.
    task automatic run_single(input logic m, input int x, input int y, input logic [31:0] a,
                              output longint xo, output longint yo, output logic [31:0] zo, output int lat);
        send(m, x, y, a);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        xo = Xout; yo = Yout; zo = Zout;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint      xo, yo;
        logic [31:0] zo;
        int          lat;

        for (int i = 0; i < 30; i++)
            atan_tab[i] = 32'($rtoi($atan(2.0 ** (-i)) * 4294967296.0 / (2.0 * 3.14159265358979) + 0.5));

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_xout", longint'(Xout), 0);
        check("rst_zout", Zout, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_single(0, 64, 0, 32'h2000_0000, xo, yo, zo, lat);
        check("rot45_latency", lat, LAT);
        check("rot45_x", absl(xo - A_ROT) <= A_RTOL, 1);
        check("rot45_y", absl(yo - A_ROT) <= A_RTOL, 1);
        check("rot45_z", angerr(zo, 32'h0) <= 65536, 1);

        run_single(0, 64, 0, 32'h6000_0000, xo, yo, zo, lat);
        check("rot135_x", absl(xo + A_ROT) <= A_RTOL, 1);
        check("rot135_y", absl(yo - A_ROT) <= A_RTOL, 1);

        run_single(0, 64, 0, 32'hA000_0000, xo, yo, zo, lat);
        check("rotm135_x", absl(xo + A_ROT) <= A_RTOL, 1);
        check("rotm135_y", absl(yo + A_ROT) <= A_RTOL, 1);

        run_single(1, 64, 64, 32'h0, xo, yo, zo, lat);
        check("vec45_x", absl(xo - A_VEC) <= 2, 1);
        check("vec45_y", absl(yo) <= 2, 1);
        check("vec45_z", angerr(zo, 32'h2000_0000) <= 6_000_000, 1);

        run_single(1, -64, -64, 32'h0, xo, yo, zo, lat);
        check("vecm135_z", angerr(zo, 32'hA000_0000) <= 6_000_000, 1);

        // Extremes go through the exact scoreboard compare.
        run_single(0, -128, -128, 32'h1234_5678, xo, yo, zo, lat);
        run_single(0, -128, -128, 32'hC000_0000, xo, yo, zo, lat);
        run_single(1, -128, -128, 32'h0, xo, yo, zo, lat);
        run_single(1, 127, -128, 32'h0, xo, yo, zo, lat);
        run_single(1, -128, 127, 32'h0, xo, yo, zo, lat);

        // 20 back-to-back mixed-mode samples with a 5-cycle consumer stall mid-stream.
        n_out = 0;
        lo_cnt = 0;
        fork
            begin
                for (int k = 0; k < 20; k++)
                    send(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $urandom);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_out, 20);
        check("stall_cycles", lo_cnt, 5);

        // Longer random stream with random input gaps and random back-pressure.
        drv_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    send(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $urandom);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Mid-stream reset with 8 samples in flight.
        for (int k = 0; k < 8; k++)
            send(1'(k % 2), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_xout", longint'(Xout), 0);
        check("mid_rst_yout", longint'(Yout), 0);
        check("mid_rst_zout", Zout, 0);
        check("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_single(0, 100, -37, 32'h3000_0000, xo, yo, zo, lat);
        check("post_rst_latency", lat, LAT);
        drain();

        check("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_stream.md
# cordic_stream

Parametrised, fully pipelined CORDIC engine with per-sample rotation/vectoring mode, full-range quadrant pre-rotation and valid/ready flow control on both sides. It succeeds the fixed rotation-only pipeline. It sits between sample producers (NCO, mixers, DSP front-end) and consumers, and accepts one sample per clock when not back-pressured.

## Interface
- BIT_WIDTH, 8: signed input sample width (X/Y); legal 4..24.
- ITERATIONS, 16: number of micro-rotation stages; legal 4..30.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  engine accepts sample this cycle.
- in_mode  in  1  0 = rotation, 1 = vectoring.
- Xin, Yin  in  BIT_WIDTH  signed two's-complement coordinates.
- angle  in  32  signed binary angle; 2^32 = 2π (0x2000_0000 = 45°); ignored in vectoring.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- Xout, Yout  out  BIT_WIDTH+2  signed results.
- Zout  out  32  residual angle (rotation) or computed angle atan2(Yin,Xin) (vectoring), same binary-angle format.

## Operation
- Internal datapath width W = BIT_WIDTH+2 for X/Y; Xin/Yin sign-extended on entry. 32-bit Z.
- Stage P (pre-rotation), registered:
  - Rotation: if angle[31:30] = 01 → x=−y, y=x, z=angle−0x4000_0000; if 10 → x=y, y=−x, z=angle+0x4000_0000; else pass-through, z=angle.
  - Vectoring: if Xin<0 and Yin≥0 → x=y, y=−x, z=0x4000_0000; if Xin<0 and Yin<0 → x=−y, y=x, z=−0x4000_0000; else pass-through, z=0.
- Stage i (i = 0..ITERATIONS−1), registered: d=+1 if (rotation: z≥0) / (vectoring: y<0), else −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_i.
  - >>> is arithmetic shift.
  - atan_i = round(atan(2^−i)·2^32/(2π)), constant table generated for all 30 entries.
- Mode bit travels with its sample through every stage.
- Without gain compensation, outputs carry CORDIC gain K≈1.64676; W bits hold worst case |Xin|,|Yin| = 2^(BIT_WIDTH−1) without overflow.
- Flow control: stall = out_valid & ~out_ready; in_ready = ~stall. When stall, every stage register (data, mode, valid) holds. Otherwise all stages advance together; bubbles (valid=0) propagate. No sample dropped or duplicated; order preserved.
- Sample accepted when in_valid & in_ready. Result transferred when out_valid & out_ready.

## Timing
- Latency: ITERATIONS+1 cycles from acceptance to out_valid with no stall (+1 with gain compensation); each stall cycle adds one.
- Throughput: one sample/clock while out_ready=1.
- in_ready is combinational from out_ready and out_valid (no registered skid).
- Reset (rst_n low, any time including mid-stream): all valid bits, data, mode and Z registers → 0 immediately. out_valid=0, Xout=Yout=Zout=0. in_ready=1 after reset. In-flight samples are discarded.
- out_valid/Xout/Yout/Zout stable while out_valid=1 and out_ready=0.

## Configuration
- CORDIC_GAIN_COMP_EN defined: extra registered output stage multiplies X and Y by 39797 (round(2^16/K)) then >>>16 (floor). Outputs ≈ true rotation/magnitude. Latency ITERATIONS+2; stage participates in stall.
- Not defined: no compensation stage; outputs scaled by K; latency ITERATIONS+1.

## Test plan
Base configuration BIT_WIDTH=8, ITERATIONS=16 unless stated.
- Rotation, (64,0), angle 0x2000_0000, no comp → out_valid exactly 17 cycles after accept; Xout=Yout=74±2; Zout within ±2^16 of 0. With CORDIC_GAIN_COMP_EN → Xout=Yout=45±1, latency 18.
- Rotation, (64,0), angle 0x6000_0000 (135°), no comp → Xout=−74±2, Yout=74±2. Angle 0xA000_0000 (−135°) → Xout=−74±2, Yout=−74±2.
- Vectoring, (64,64) → Xout=149±2, Yout=0±2, Zout=0x2000_0000±6_000_000. (−64,−64) → Zout=0xA000_0000±6_000_000.
- Stream of 20 back-to-back mixed-mode samples, out_ready low for 5 cycles mid-stream → in_ready low exactly during stall; all 20 results emerge in order, each matching the scoreboard model; none lost or duplicated.
- Extremes: Xin=−128, Yin=−128, both modes → no wrap; results match a bit-accurate model exactly.
- Assert rst_n low for 1 cycle with 8 samples in flight → out_valid=0 and outputs 0 immediately. After release, no stale result appears; a new sample returns after the nominal latency.
